// File: rtl/fft_stage_sequencer.sv
// Address and control sequencer for one radix-2 FFT stage (DIF or DIT ordering).
// Issues one coefficient pair per cycle and replays the pair addresses for in-place writeback.
module fft_stage_sequencer #(
  parameter int LOGN        = 10,
  parameter int RD_LATENCY  = 1,
  parameter int BTF_LATENCY = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       dif_dit,
  input  logic [$clog2(LOGN+1)-1:0]  stage,
  output logic                       rd_en,
  output logic [LOGN-1:0]            rd_addr_a,
  output logic [LOGN-1:0]            rd_addr_b,
  output logic [LOGN-2:0]            tw_addr,
  output logic                       btf_valid,
  output logic                       btf_dif_dit,
  output logic                       wr_en,
  output logic [LOGN-1:0]            wr_addr_a,
  output logic [LOGN-1:0]            wr_addr_b,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int LW = $clog2(LOGN);
  localparam int L  = RD_LATENCY + BTF_LATENCY;
  localparam int CW = $clog2(L);
  localparam logic [LOGN-1:0] HALF = LOGN'(1'b1) << (LOGN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_r;
  logic [LOGN-1:0]  k_r;
  logic [LW-1:0]    ld_r;
  logic [CW-1:0]    cnt_r;
  logic [LW-1:0]    ld_in_s;
  logic             stage_ok_s;
  logic             rv_r [RD_LATENCY];
  logic [2*LOGN:0]  wp_r [L];

  function automatic logic [LOGN-1:0] pair_mask(input logic [LW-1:0] ld);
    return (LOGN'(1'b1) << ld) - LOGN'(1'b1);
  endfunction

  // The even address is k with a zero bit inserted at position ld.
  function automatic logic [LOGN-1:0] addr_even(input logic [LOGN-1:0] k, input logic [LW-1:0] ld);
    logic [LOGN-1:0] m;
    m = pair_mask(ld);
    return ((k & ~m) << 1) | (k & m);
  endfunction

  function automatic logic [LOGN-2:0] tw_of(input logic [LOGN-1:0] k, input logic [LW-1:0] ld);
    logic [LOGN-1:0] t;
    t = (k & pair_mask(ld)) << (LOGN - 1 - int'(ld));
    return t[LOGN-2:0];
  endfunction

  // Decode the requested stage into log2 of the pair distance.
  always_comb begin
    stage_ok_s = (int'(stage) < LOGN);
    if (dif_dit) begin
      ld_in_s = LW'(stage);
    end else begin
      ld_in_s = LW'(LOGN - 1 - int'(stage));
    end
  end

  // Stage control FSM with registered read-side and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= '0;
      ld_r        <= '0;
      cnt_r       <= '0;
      rd_en       <= 1'b0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      tw_addr     <= '0;
      btf_dif_dit <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            btf_dif_dit <= dif_dit;
            err         <= ~stage_ok_s;
            ld_r        <= ld_in_s;
            k_r         <= LOGN'(1'b1);
            if (stage_ok_s) begin
              state_r   <= ISSUE;
              rd_en     <= 1'b1;
              rd_addr_a <= '0;
              rd_addr_b <= LOGN'(1'b1) << ld_in_s;
              tw_addr   <= '0;
              busy      <= 1'b1;
            end else begin
              state_r <= FINISH;
              done    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (k_r == HALF) begin
            state_r   <= DRAIN;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            cnt_r     <= '0;
          end else begin
            rd_addr_a <= addr_even(k_r, ld_r);
            rd_addr_b <= addr_even(k_r, ld_r) | (LOGN'(1'b1) << ld_r);
            tw_addr   <= tw_of(k_r, ld_r);
            k_r       <= k_r + LOGN'(1'b1);
          end
        end
        DRAIN: begin
          // The last pair leaves the writeback pipe after exactly L drain cycles.
          if (cnt_r == CW'(L - 1)) begin
            state_r <= FINISH;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          rd_en   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency delay line for the butterfly input valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) rv_r[i] <= 1'b0;
    end else begin
      rv_r[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) rv_r[i] <= rv_r[i-1];
    end
  end

  // Writeback delay line carrying strobe and pair addresses through read and butterfly latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) wp_r[i] <= '0;
    end else begin
      wp_r[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < L; i++) wp_r[i] <= wp_r[i-1];
    end
  end

  assign btf_valid                        = rv_r[RD_LATENCY-1];
  assign {wr_en, wr_addr_a, wr_addr_b}    = wp_r[L-1];

endmodule
